nvram_upload: RTL

- HPS-facing responder for the ioctl upload (save) direction. It is the read-back counterpart of the ioctl download writer that loads ROM and DIP data.
- Serves byte reads of the game's NVRAM/hiscore RAM to the HPS and stretches each read with ioctl_wait until data is valid.
- Tracks game writes, so the framework can be told when a save is worthwhile.
- Sits between hps_io and the second port of the NVRAM dpram in the core top level.

---
 rtl/nvram_upload.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/nvram_upload.sv
// nvram_upload: HPS upload (save) responder for the game NVRAM.
// Serves byte reads from the second dpram port, stretches each read with
// ioctl_wait, and tracks game writes in a dirty flag.
// Optional build macro: NVRAM_UPLOAD_CKSUM_EN appends a checksum byte at
// address SIZE so the uploaded image sums to zero mod 256.
module nvram_upload #(
    parameter int unsigned AW     = 10,
    parameter int unsigned INDEX  = 4,
    parameter int unsigned RD_LAT = 1
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          ioctl_upload,
    input  logic [7:0]    ioctl_index,
    input  logic          ioctl_rd,
    input  logic [24:0]   ioctl_addr,
    output logic [7:0]    ioctl_din,
    output logic          ioctl_wait,
    output logic          pause_cpu,
    input  logic          grant,
    output logic [AW-1:0] ram_addr,
    output logic          ram_rd,
    input  logic [7:0]    ram_q,
    input  logic          game_wr,
    output logic          dirty
);

    localparam int unsigned SIZE = 2 ** AW;
    localparam int unsigned CW   = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        LAT   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state_q, state_nxt;
    logic [AW-1:0]   addr_q, addr_nxt;
    logic [CW-1:0]   cnt_q, cnt_nxt;
    logic [7:0]      din_nxt;
    logic            wait_nxt;
    logic            rd_nxt;
    logic [AW-1:0]   raddr_nxt;
    logic            wr_seen;
    logic            active_c;
    logic            active_rise_c;
    logic            active_fall_c;
    logic [7:0]      oor_val_c;

    // pause_cpu doubles as the one-cycle-delayed copy of active
    assign active_c      = ioctl_upload && (ioctl_index == 8'(INDEX));
    assign active_rise_c = active_c && !pause_cpu;
    assign active_fall_c = !active_c && pause_cpu;

`ifdef NVRAM_UPLOAD_CKSUM_EN
    logic [7:0] sum_q, sum_nxt;

    // Address SIZE returns the two's-complement of the running sum
    always_comb begin
        oor_val_c = 8'hFF;
        if (ioctl_addr == 25'(SIZE)) begin
            oor_val_c = 8'h00 - sum_q;
        end
    end
`else
    assign oor_val_c = 8'hFF;
`endif

    // Next-state and next-output logic for the read FSM
    always_comb begin
        state_nxt = state_q;
        addr_nxt  = addr_q;
        cnt_nxt   = cnt_q;
        din_nxt   = ioctl_din;
        wait_nxt  = ioctl_wait;
        rd_nxt    = 1'b0;
        raddr_nxt = ram_addr;
`ifdef NVRAM_UPLOAD_CKSUM_EN
        sum_nxt   = sum_q;
        if (active_rise_c) begin
            sum_nxt = 8'h00;
        end
`endif
        if (!active_c) begin
            // Session ended: abandon any read in flight, keep last data
            state_nxt = IDLE;
            wait_nxt  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ioctl_rd) begin
                        wait_nxt = 1'b1;
                        addr_nxt = ioctl_addr[AW-1:0];
                        // Full-width compare: upper bits never wrap into the RAM
                        if (ioctl_addr >= 25'(SIZE)) begin
                            din_nxt   = oor_val_c;
                            state_nxt = DONE;
                        end else begin
                            state_nxt = GRANT;
                        end
                    end
                end
                GRANT: begin
                    if (grant) begin
                        raddr_nxt = addr_q;
                        rd_nxt    = 1'b1;
                        cnt_nxt   = '0;
                        state_nxt = LAT;
                    end
                end
                LAT: begin
                    // First LAT cycle is the ram_rd cycle; data valid RD_LAT later
                    if (cnt_q == CW'(RD_LAT)) begin
                        din_nxt   = ram_q;
`ifdef NVRAM_UPLOAD_CKSUM_EN
                        sum_nxt   = sum_q + ram_q;
`endif
                        state_nxt = DONE;
                    end else begin
                        cnt_nxt = cnt_q + CW'(1);
                    end
                end
                DONE: begin
                    wait_nxt  = 1'b0;
                    state_nxt = IDLE;
                end
                default: begin
                    wait_nxt  = 1'b0;
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // FSM state and registered outputs
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            cnt_q      <= '0;
            ioctl_din  <= 8'hFF;
            ioctl_wait <= 1'b0;
            ram_rd     <= 1'b0;
            ram_addr   <= '0;
            pause_cpu  <= 1'b0;
`ifdef NVRAM_UPLOAD_CKSUM_EN
            sum_q      <= 8'h00;
`endif
        end else begin
            state_q    <= state_nxt;
            addr_q     <= addr_nxt;
            cnt_q      <= cnt_nxt;
            ioctl_din  <= din_nxt;
            ioctl_wait <= wait_nxt;
            ram_rd     <= rd_nxt;
            ram_addr   <= raddr_nxt;
            pause_cpu  <= active_c;
`ifdef NVRAM_UPLOAD_CKSUM_EN
            sum_q      <= sum_nxt;
`endif
        end
    end

    // Dirty tracking: a session without game writes clears dirty when it ends
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            wr_seen <= 1'b0;
            dirty   <= 1'b0;
        end else begin
            if (active_rise_c) begin
                wr_seen <= game_wr;
            end else if (active_c && game_wr) begin
                wr_seen <= 1'b1;
            end
            if (game_wr) begin
                dirty <= 1'b1;
            end else if (active_fall_c && !wr_seen) begin
                dirty <= 1'b0;
            end
        end
    end

endmodule
